// File: rtl/bus_interconnect_if.sv
// Master bus plus NUM_DEVICES slave buses of the interconnect.
// Slave read data is packed with slot i holding port i.
interface bus_interconnect_if #(
  parameter int N = 4
);
  logic          m_valid;
  logic [31:0]   m_address;
  logic [3:0]    m_wstrobe;
  logic [31:0]   m_wdata;
  logic [31:0]   m_rdata;
  logic          m_ready;
  logic          m_irq;
  logic [N-1:0]  s_valid;
  logic [31:0]   s_address;
  logic [3:0]    s_wstrobe;
  logic [31:0]   s_wdata;
  logic [N*32-1:0] s_rdata;
  logic [N-1:0]  s_ready;
  logic [N-1:0]  s_irq;

  modport master (
    output m_valid, m_address, m_wstrobe, m_wdata,
    input  m_rdata, m_ready, m_irq
  );

  modport slave (
    input  s_valid, s_address, s_wstrobe, s_wdata,
    output s_rdata, s_ready, s_irq
  );

  modport fabric (
    input  m_valid, m_address, m_wstrobe, m_wdata,
    output m_rdata, m_ready, m_irq,
    output s_valid, s_address, s_wstrobe, s_wdata,
    input  s_rdata, s_ready, s_irq
  );
endinterface

// File: rtl/bus_interconnect.sv
// One-master, NUM_DEVICES-slave decoder with unmapped responder,
// timeout watchdog, sticky error capture and masked irq aggregation.
module bus_interconnect #(
  parameter int NUM_DEVICES = 4,
  parameter logic [NUM_DEVICES*8-1:0] DEV_BASES =
    {8'h81, 8'h80, 8'h00, 8'h00},
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF,
  parameter logic [NUM_DEVICES-1:0] IRQ_MASK = '1
) (
  input  logic        clk,
  input  logic        reset,
  bus_interconnect_if.fabric bus,
  input  logic        err_clear,
  output logic        err_timeout,
  output logic        err_unmapped,
  output logic [31:0] err_address
);

  localparam int IW = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    TOUT
  } state_t;

  state_t  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [IW-1:0] sel_q, sel_d;
  logic [IW-1:0] hit_idx;
  logic          hit;
  logic [NUM_DEVICES-1:0] sv;
  logic [31:0] rd [NUM_DEVICES];
  logic        set_to, set_um;

  assign bus.s_address = bus.m_address;
  assign bus.s_wstrobe = bus.m_wstrobe;
  assign bus.s_wdata   = bus.m_wdata;
  assign bus.s_valid   = sv;
  assign bus.m_irq     = |(bus.s_irq & IRQ_MASK);

  always_comb begin
    for (int i = 0; i < NUM_DEVICES; i++)
      rd[i] = bus.s_rdata[i*32 +: 32];
  end

  // Scan downward so the lowest matching index is the one kept.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (bus.m_address[31:24] == DEV_BASES[i*8 +: 8]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    sv          = '0;
    bus.m_ready = 1'b0;
    bus.m_rdata = '0;
    set_to      = 1'b0;
    set_um      = 1'b0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          if (bus.m_valid && hit) begin
            sv[hit_idx]  = 1'b1;
            bus.m_ready  = bus.s_ready[hit_idx];
            bus.m_rdata  = rd[hit_idx];
            if (!bus.s_ready[hit_idx]) begin
              sel_d   = hit_idx;
              cnt_d   = 16'd1;
              state_d = BUSY;
            end
          end else if (bus.m_valid) begin
            bus.m_ready = 1'b1;
            set_um      = 1'b1;
          end
        end
        BUSY: begin
          if (!bus.m_valid) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            sv[sel_q]   = 1'b1;
            bus.m_ready = bus.s_ready[sel_q];
            bus.m_rdata = rd[sel_q];
            if (bus.s_ready[sel_q]) begin
              cnt_d   = '0;
              state_d = IDLE;
            end else if (cnt_q >= TMO) begin
              state_d = TOUT;
            end else if (cnt_q != 16'hFFFF) begin
              cnt_d = cnt_q + 16'd1;
            end
          end
        end
        TOUT: begin
          bus.m_ready = 1'b1;
          bus.m_rdata = ERR_DATA;
          set_to      = 1'b1;
          cnt_d       = '0;
          state_d     = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
    end
  end

  // A clear in the same cycle as a new error drops that error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
      err_address  <= '0;
    end else if (err_clear) begin
      err_timeout  <= 1'b0;
      err_unmapped <= 1'b0;
      err_address  <= '0;
    end else if (set_to || set_um) begin
      if (!err_timeout && !err_unmapped)
        err_address <= bus.m_address;
      if (set_to)
        err_timeout <= 1'b1;
      if (set_um)
        err_unmapped <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_interconnect.sv
// Random-traffic scoreboard bench for bus_interconnect.
// Expected responses come from address-map and latency rules.
module tb_bus_interconnect;

  localparam int TMO = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic err_clear = 1'b0;
  logic err_timeout, err_unmapped;
  logic [31:0] err_address;

  int tests = 0;
  int fails = 0;

  bus_interconnect_if #(.N(4)) bus ();

  bus_interconnect #(
    .NUM_DEVICES   (4),
    .DEV_BASES     ({8'h81, 8'h80, 8'h00, 8'h00}),
    .TIMEOUT_CYCLES(TMO),
    .ERR_DATA      (32'hDEADBEEF),
    .IRQ_MASK      (4'b0110)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .err_clear   (err_clear),
    .err_timeout (err_timeout),
    .err_unmapped(err_unmapped),
    .err_address (err_address)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    logic [31:0] rdata;
    logic [3:0]  sv;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];

  // Slave model: every port answers after cur_lat wait cycles.
  int          cur_lat = 0;
  logic [31:0] cur_data = '0;
  int          wcnt = 0;

  always @(posedge clk) begin
    if (!bus.m_valid || bus.m_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  always_comb begin
    for (int i = 0; i < 4; i++)
      bus.s_ready[i] = bus.s_valid[i] && (wcnt >= cur_lat);
  end

  assign bus.s_rdata = {4{cur_data}};

  // Reference error state
  logic        m_to = 0, m_um = 0;
  logic [31:0] m_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per completed handshake.
  int mcyc = 0;
  always @(negedge clk) begin
    if (!reset || !bus.m_valid) begin
      mcyc = 0;
    end else if (bus.m_ready) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ready: got ready expected none");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 32'(mcyc), 32'(e.cycles));
        chk("rdata", bus.m_rdata, e.rdata);
        chk("s_valid", 32'(bus.s_valid), 32'(e.sv));
        chk("s_address", bus.s_address, e.addr);
        chk("s_wdata", bus.s_wdata, e.wdata);
      end
      mcyc = 0;
    end else begin
      mcyc++;
    end
  end

  function automatic int decode(input logic [31:0] a);
    logic [7:0] bases [4];
    bases = '{8'h00, 8'h00, 8'h80, 8'h81};
    for (int i = 0; i < 4; i++)
      if (a[31:24] == bases[i]) return i;
    return -1;
  endfunction

  task automatic check_errs();
    chk("err_timeout", 32'(err_timeout), 32'(m_to));
    chk("err_unmapped", 32'(err_unmapped), 32'(m_um));
    if (m_to || m_um)
      chk("err_address", err_address, m_addr);
  endtask

  task automatic txn(input logic [31:0] a, input int lat,
                     input logic [31:0] d, input logic [3:0] ws,
                     input bit clr);
    exp_t e;
    int idx;
    bit err_t, err_u, done;
    logic [31:0] wd;
    wd = $urandom;
    idx = decode(a);
    err_t = 0;
    err_u = 0;
    e.addr = a;
    e.wdata = wd;
    if (idx < 0) begin
      e.cycles = 0; e.rdata = '0; e.sv = '0; err_u = 1;
    end else if (lat <= TMO) begin
      e.cycles = lat; e.rdata = d; e.sv = 4'(1 << idx);
    end else begin
      e.cycles = TMO + 1; e.rdata = 32'hDEADBEEF;
      e.sv = '0; err_t = 1;
    end
    q.push_back(e);
    cur_lat = lat;
    cur_data = d;
    bus.m_address = a;
    bus.m_wstrobe = ws;
    bus.m_wdata = wd;
    bus.m_valid = 1'b1;
    err_clear = clr;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (bus.m_ready) done = 1;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL handshake: got no ready expected ready");
      void'(q.pop_front());
    end
    @(posedge clk);
    #1;
    bus.m_valid = 1'b0;
    err_clear = 1'b0;
    if (clr) begin
      m_to = 0; m_um = 0; m_addr = '0;
    end else if (err_t || err_u) begin
      if (!m_to && !m_um) m_addr = a;
      m_to = m_to | err_t;
      m_um = m_um | err_u;
    end
    @(negedge clk);
    chk("idle_ready", 32'(bus.m_ready), 32'd0);
    chk("idle_rdata", bus.m_rdata, 32'd0);
    check_errs();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulse();
    err_clear = 1'b1;
    @(posedge clk);
    #1;
    err_clear = 1'b0;
    m_to = 0; m_um = 0; m_addr = '0;
    @(negedge clk);
    check_errs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  top;
    int          r;
    bus.m_valid = 1'b0;
    bus.m_address = '0;
    bus.m_wstrobe = '0;
    bus.m_wdata = '0;
    bus.s_irq = '0;
    #12;
    chk("rst_s_valid", 32'(bus.s_valid), 32'd0);
    chk("rst_ready", 32'(bus.m_ready), 32'd0);
    chk("rst_err_address", err_address, 32'd0);
    check_errs();
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    txn(32'h80000004, 2, 32'h12345678, 4'h0, 0);
    txn(32'h00000010, 0, 32'hA5A5A5A5, 4'hF, 0);
    txn(32'h42000000, 0, 32'h11111111, 4'h0, 0);
    txn(32'h43000000, 0, 32'h22222222, 4'h0, 0);
    clear_pulse();
    txn(32'h81000000, 100, 32'h33333333, 4'h0, 0);
    clear_pulse();
    txn(32'h81000020, TMO, 32'hCAFEF00D, 4'h0, 0);
    txn(32'h81000024, TMO + 1, 32'h0BADF00D, 4'h3, 0);
    txn(32'h7F000000, 0, 32'h0, 4'h0, 1);

    // Reset in the middle of a wait state
    cur_lat = 100;
    bus.m_address = 32'h80000000;
    bus.m_wstrobe = 4'h0;
    bus.m_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_s_valid", 32'(bus.s_valid), 32'h4);
    #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_s_valid", 32'(bus.s_valid), 32'd0);
    chk("rst_mid_ready", 32'(bus.m_ready), 32'd0);
    @(posedge clk);
    #1;
    bus.m_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    m_to = 0; m_um = 0; m_addr = '0;
    @(posedge clk);
    #1;
    txn(32'h80000100, 3, 32'h5555AAAA, 4'h0, 0);

    bus.s_irq = 4'b1001;
    #1;
    chk("irq_masked", 32'(bus.m_irq), 32'd0);
    bus.s_irq = 4'b0100;
    #1;
    chk("irq_pass", 32'(bus.m_irq), 32'd1);
    for (int i = 0; i < 8; i++) begin
      bus.s_irq = 4'($urandom);
      #1;
      chk("irq_rand", 32'(bus.m_irq), 32'(|(bus.s_irq & 4'b0110)));
    end
    bus.s_irq = '0;

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 4);
      a = $urandom;
      case (r)
        0, 4: a[31:24] = 8'h00;
        1: a[31:24] = 8'h80;
        2: a[31:24] = 8'h81;
        default: begin
          top = 8'($urandom);
          while (top == 8'h00 || top == 8'h80 || top == 8'h81)
            top = 8'($urandom);
          a[31:24] = top;
        end
      endcase
      txn(a, $urandom_range(0, 11), $urandom,
          4'($urandom), (r == 3) && ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 5) == 0) clear_pulse();
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
